multicycle_controller: RTL and testbench

//  Multicycle control unit for the ARM-subset core: main FSM, instruction decoder and flag/condition logic.

---
 rtl/multicycle_controller_pkg.sv | 74 +++++++
 rtl/multicycle_controller_if.sv | 33 +++
 rtl/multicycle_controller_cond_check.sv | 36 +++
 rtl/multicycle_controller.sv | 169 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the ARM-subset multicycle control unit.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef struct packed {
        logic       valid;
        logic       arith;
        logic       is_cmp;
        logic [2:0] ctrl;
    } cmd_dec_t;

    // Unsupported commands decode to ADD with valid clear so nothing gets written.
    function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd, input logic eor_en);
        cmd_dec_t d;
        d = '{valid: 1'b0, arith: 1'b0, is_cmp: 1'b0, ctrl: ALU_ADD};
        case (cmd)
            CMD_ADD: d = '{valid: 1'b1, arith: 1'b1, is_cmp: 1'b0, ctrl: ALU_ADD};
            CMD_SUB: d = '{valid: 1'b1, arith: 1'b1, is_cmp: 1'b0, ctrl: ALU_SUB};
            CMD_AND: d = '{valid: 1'b1, arith: 1'b0, is_cmp: 1'b0, ctrl: ALU_AND};
            CMD_ORR: d = '{valid: 1'b1, arith: 1'b0, is_cmp: 1'b0, ctrl: ALU_ORR};
            CMD_CMP: d = '{valid: 1'b1, arith: 1'b1, is_cmp: 1'b1, ctrl: ALU_SUB};
            CMD_EOR: d = '{valid: eor_en, arith: 1'b0, is_cmp: 1'b0, ctrl: eor_en ? ALU_EOR : ALU_ADD};
            default: d = '{valid: 1'b0, arith: 1'b0, is_cmp: 1'b0, ctrl: ALU_ADD};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction/flag inputs and datapath control outputs of the multicycle control unit.
interface multicycle_controller_if #(
    parameter int ALUCTRL_W = 2,
    parameter int CNT_W     = 32
);
    logic [31:12]          Instr;
    logic [3:0]            ALUFlags;
    logic                  mem_ready;
    logic                  PCWrite;
    logic                  AdrSrc;
    logic                  MemWrite;
    logic                  IRWrite;
    logic [1:0]            ResultSrc;
    logic                  ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic                  RegWrite;
    logic [1:0]            ImmSrc;
    logic [1:0]            RegSrc;
    logic [ALUCTRL_W-1:0]  ALUControl;
    logic [CNT_W-1:0]      retired_cnt;

    modport master (
        input  Instr, ALUFlags, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, RegSrc, ALUControl, retired_cnt
    );

    modport slave (
        output Instr, ALUFlags, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, RegSrc, ALUControl, retired_cnt
    );
endinterface

// File: rtl/multicycle_controller_cond_check.sv
// Evaluates an ARM condition field against the registered NZCV flags.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       cond_ex
);
    logic n_s, z_s, c_s, v_s, ge_s;

    assign {n_s, z_s, c_s, v_s} = nzcv;
    assign ge_s = (n_s == v_s);

    // Condition table; 1111 is treated as never-execute.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z_s;
            COND_NE: cond_ex = ~z_s;
            COND_CS: cond_ex = c_s;
            COND_CC: cond_ex = ~c_s;
            COND_MI: cond_ex = n_s;
            COND_PL: cond_ex = ~n_s;
            COND_VS: cond_ex = v_s;
            COND_VC: cond_ex = ~v_s;
            COND_HI: cond_ex = c_s & ~z_s;
            COND_LS: cond_ex = ~c_s | z_s;
            COND_GE: cond_ex = ge_s;
            COND_LT: cond_ex = ~ge_s;
            COND_GT: cond_ex = ~z_s & ge_s;
            COND_LE: cond_ex = z_s | ~ge_s;
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control unit: main FSM, instruction decode, NZCV register and retired counter.
module multicycle_controller
    import arm_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 2,
    parameter int MEM_HS    = 1,
    parameter int CNT_W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_controller_if.master  bus
);
    state_t           state_r, state_s;
    logic [3:0]       nzcv_r;
    logic [CNT_W-1:0] cnt_r;
    logic             cond_ex_s, ready_s, retire_s;
    logic [1:0]       flag_w_s;
    logic [2:0]       alu3_s;
    logic [1:0]       op_s;
    logic [5:0]       funct_s;
    logic             rd_pc_s;
    cmd_dec_t         dec_s;

    logic       pc_write_s, adr_src_s, mem_write_s, ir_write_s, alu_src_a_s, reg_write_s;
    logic [1:0] result_src_s, alu_src_b_s, imm_src_s, reg_src_s;

    assign ready_s = (MEM_HS != 0) ? bus.mem_ready : 1'b1;
    assign op_s    = bus.Instr[27:26];
    assign funct_s = bus.Instr[25:20];
    assign rd_pc_s = (bus.Instr[15:12] == 4'd15);
    assign dec_s   = decode_cmd(funct_s[4:1], (ALUCTRL_W >= 3) ? 1'b1 : 1'b0);

    cond_check u_cond (
        .cond    (bus.Instr[31:28]),
        .nzcv    (nzcv_r),
        .cond_ex (cond_ex_s)
    );

    // Next-state and per-state control outputs; everything is held at 0 while in reset.
    always_comb begin
        state_s      = state_r;
        pc_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        alu_src_a_s  = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = 2'b00;
        alu_src_b_s  = 2'b00;
        imm_src_s    = 2'b00;
        reg_src_s    = 2'b00;
        alu3_s       = ALU_ADD;
        flag_w_s     = 2'b00;
        retire_s     = 1'b0;
        if (reset) begin
            case (state_r)
                S_FETCH: begin
                    alu_src_a_s  = 1'b1;
                    alu_src_b_s  = 2'b10;
                    result_src_s = 2'b10;
                    ir_write_s   = ready_s;
                    pc_write_s   = ready_s;
                    state_s      = ready_s ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_a_s  = 1'b1;
                    alu_src_b_s  = 2'b10;
                    result_src_s = 2'b10;
                    imm_src_s    = (op_s == OP_ILL) ? 2'b00 : op_s;
                    reg_src_s    = {(op_s == OP_MEM) & ~funct_s[0], (op_s == OP_BR)};
                    if (!cond_ex_s) begin
                        state_s  = S_FETCH;
                        retire_s = 1'b1;
                    end else begin
                        case (op_s)
                            OP_DP:   state_s = funct_s[5] ? S_EXECUTEI : S_EXECUTER;
                            OP_MEM:  state_s = S_MEMADR;
                            OP_BR:   state_s = S_BRANCH;
                            default: state_s = S_FETCH;
                        endcase
                    end
                end
                S_EXECUTER, S_EXECUTEI: begin
                    alu_src_b_s = (state_r == S_EXECUTEI) ? 2'b01 : 2'b00;
                    alu3_s      = dec_s.ctrl;
                    // CMP always updates all four flags regardless of the S bit.
                    flag_w_s    = {dec_s.valid & (funct_s[0] | dec_s.is_cmp),
                                   dec_s.valid & ((funct_s[0] & dec_s.arith) | dec_s.is_cmp)};
                    if (!dec_s.valid || dec_s.is_cmp) begin
                        state_s  = S_FETCH;
                        retire_s = 1'b1;
                    end else begin
                        state_s  = S_ALUWB;
                    end
                end
                S_ALUWB: begin
                    pc_write_s  = rd_pc_s;
                    reg_write_s = ~rd_pc_s;
                    state_s     = S_FETCH;
                    retire_s    = 1'b1;
                end
                S_MEMADR: begin
                    alu_src_b_s = 2'b01;
                    state_s     = funct_s[0] ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    adr_src_s = 1'b1;
                    state_s   = ready_s ? S_MEMWB : S_MEMREAD;
                end
                S_MEMWB: begin
                    result_src_s = 2'b01;
                    pc_write_s   = rd_pc_s;
                    reg_write_s  = ~rd_pc_s;
                    state_s      = S_FETCH;
                    retire_s     = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src_s   = 1'b1;
                    mem_write_s = 1'b1;
                    state_s     = ready_s ? S_FETCH : S_MEMWRITE;
                    retire_s    = ready_s;
                end
                S_BRANCH: begin
                    alu_src_b_s  = 2'b01;
                    result_src_s = 2'b10;
                    pc_write_s   = 1'b1;
                    state_s      = S_FETCH;
                    retire_s     = 1'b1;
                end
                default: begin
                    state_s = S_FETCH;
                end
            endcase
        end else begin
            state_s = S_FETCH;
        end
    end

    // State, flag and retired-instruction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH;
            nzcv_r  <= 4'b0000;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (flag_w_s[1]) begin
                nzcv_r[3:2] <= bus.ALUFlags[3:2];
            end
            if (flag_w_s[0]) begin
                nzcv_r[1:0] <= bus.ALUFlags[1:0];
            end
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, retire_s};
        end
    end

    assign bus.PCWrite     = pc_write_s;
    assign bus.AdrSrc      = adr_src_s;
    assign bus.MemWrite    = mem_write_s;
    assign bus.IRWrite     = ir_write_s;
    assign bus.ResultSrc   = result_src_s;
    assign bus.ALUSrcA     = alu_src_a_s;
    assign bus.ALUSrcB     = alu_src_b_s;
    assign bus.RegWrite    = reg_write_s;
    assign bus.ImmSrc      = imm_src_s;
    assign bus.RegSrc      = reg_src_s;
    assign bus.ALUControl  = ALUCTRL_W'(alu3_s);
    assign bus.retired_cnt = cnt_r;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and randomized bench for multicycle_controller against an instruction-level model.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    logic [3:0]  m_nzcv;
    logic [31:0] m_cnt;
    logic [15:0] obs_s;

    always #5 clk = ~clk;

    multicycle_controller_if #(.ALUCTRL_W(2), .CNT_W(32)) bus ();
    multicycle_controller_if #(.ALUCTRL_W(2), .CNT_W(4))  bus4 ();

    assign bus4.Instr     = bus.Instr;
    assign bus4.ALUFlags  = bus.ALUFlags;
    assign bus4.mem_ready = bus.mem_ready;

    multicycle_controller #(.ALUCTRL_W(2), .MEM_HS(1), .CNT_W(32)) dut (
        .clk (clk), .reset (reset), .bus (bus.master)
    );
    multicycle_controller #(.ALUCTRL_W(2), .MEM_HS(1), .CNT_W(4)) dut4 (
        .clk (clk), .reset (reset), .bus (bus4.master)
    );

    assign obs_s = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                    bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.ImmSrc, bus.RegSrc,
                    bus.ALUControl};

    function automatic logic [15:0] cw(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] res,
                                       input logic srca, input logic [1:0] srcb,
                                       input logic rw, input logic [1:0] imm,
                                       input logic [1:0] rs, input logic [1:0] aluc);
        return {pcw, adr, mw, irw, res, srca, srcb, rw, imm, rs, aluc};
    endfunction

    // Condition meaning from the ARM condition table, evaluated on named flags.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ALUControl value for a data-processing command, or -1 when unsupported (2-bit ALU).
    function automatic int model_cmd(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 0;
            4'b0010: return 1;
            4'b0000: return 2;
            4'b1100: return 3;
            4'b1010: return 1;
            default: return -1;
        endcase
    endfunction

    task automatic step(input logic [15:0] exp, input logic rdy, input logic [3:0] flg,
                        input string tag);
        bus.mem_ready = rdy;
        bus.ALUFlags  = flg;
        @(negedge clk);
        vectors++;
        assert (obs_s === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs_s, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        logic [3:0] low;
        low = m_cnt[3:0];
        vectors++;
        assert (bus.retired_cnt === m_cnt) else begin
            miscompares++;
            $error("FAIL %s cnt: got %0d expected %0d", tag, bus.retired_cnt, m_cnt);
        end
        vectors++;
        assert (bus4.retired_cnt === low) else begin
            miscompares++;
            $error("FAIL %s cnt4: got %0d expected %0d", tag, bus4.retired_cnt, low);
        end
    endtask

    // Runs one instruction through the expected cycle-by-cycle control sequence.
    task automatic run_instr(input logic [19:0] ins, input logic [3:0] exf, input int fst,
                             input int mst, input bit abort);
        logic [3:0]  c, cmd;
        logic [1:0]  op, imm, rs, aluc;
        logic [5:0]  fn;
        bit          to_pc;
        int          alu;
        logic [15:0] zero;
        c = ins[19:16]; op = ins[15:14]; fn = ins[13:8]; to_pc = (ins[3:0] == 4'd15);
        cmd = fn[4:1];
        zero = 16'h0000;
        bus.Instr = ins;
        check_cnt("start");
        for (int i = 0; i < fst; i++)
            step(cw(0, 0, 0, 0, 2'b10, 1, 2'b10, 0, 2'b00, 2'b00, 2'b00), 1'b0, 4'($urandom), "fetch_wait");
        step(cw(1, 0, 0, 1, 2'b10, 1, 2'b10, 0, 2'b00, 2'b00, 2'b00), 1'b1, 4'($urandom), "fetch");
        imm = (op == 2'b11) ? 2'b00 : op;
        rs  = {(op == 2'b01) && !fn[0], op == 2'b10};
        step(cw(0, 0, 0, 0, 2'b10, 1, 2'b10, 0, imm, rs, 2'b00), 1'b1, 4'($urandom), "decode");
        if (!cond_ok(c, m_nzcv)) begin
            m_cnt++;
            return;
        end
        case (op)
            2'b00: begin
                alu = model_cmd(cmd);
                aluc = (alu < 0) ? 2'b00 : 2'(alu);
                step(cw(0, 0, 0, 0, 2'b00, 0, fn[5] ? 2'b01 : 2'b00, 0, 2'b00, 2'b00, aluc),
                     1'b1, exf, "execute");
                if (alu < 0) begin
                    m_cnt++;
                    return;
                end
                if (cmd == 4'b1010) begin
                    m_nzcv = exf;
                    m_cnt++;
                    return;
                end
                if (fn[0]) begin
                    m_nzcv[3:2] = exf[3:2];
                    if (cmd == 4'b0100 || cmd == 4'b0010) m_nzcv[1:0] = exf[1:0];
                end
                step(cw(to_pc, 0, 0, 0, 2'b00, 0, 2'b00, !to_pc, 2'b00, 2'b00, 2'b00),
                     1'b1, 4'($urandom), "aluwb");
                m_cnt++;
            end
            2'b01: begin
                step(cw(0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00), 1'b1, 4'($urandom), "memadr");
                if (fn[0]) begin
                    for (int i = 0; i < mst; i++)
                        step(cw(0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00), 1'b0, 4'($urandom), "memread_wait");
                    if (abort) begin
                        reset = 1'b0;
                        m_nzcv = 4'b0000;
                        m_cnt = 32'd0;
                        #1;
                        step(zero, 1'b1, 4'($urandom), "reset_outputs");
                        check_cnt("reset");
                        reset = 1'b1;
                        return;
                    end
                    step(cw(0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00), 1'b1, 4'($urandom), "memread");
                    step(cw(to_pc, 0, 0, 0, 2'b01, 0, 2'b00, !to_pc, 2'b00, 2'b00, 2'b00),
                         1'b1, 4'($urandom), "memwb");
                end else begin
                    for (int i = 0; i < mst; i++)
                        step(cw(0, 1, 1, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00), 1'b0, 4'($urandom), "memwrite_wait");
                    step(cw(0, 1, 1, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00), 1'b1, 4'($urandom), "memwrite");
                end
                m_cnt++;
            end
            2'b10: begin
                step(cw(1, 0, 0, 0, 2'b10, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00), 1'b1, 4'($urandom), "branch");
                m_cnt++;
            end
            default: begin
                // illegal op: back to fetch without counting
            end
        endcase
    endtask

    function automatic logic [19:0] rand_instr();
        logic [3:0] c, cmd;
        logic [1:0] op;
        logic [5:0] fn;
        int r;
        c = ($urandom_range(0, 9) < 6) ? 4'hE : 4'($urandom);
        r = $urandom_range(0, 9);
        op = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        fn = 6'($urandom);
        if (op == 2'b00) begin
            case ($urandom_range(0, 6))
                0: cmd = 4'b0100;
                1: cmd = 4'b0010;
                2: cmd = 4'b0000;
                3: cmd = 4'b1100;
                4: cmd = 4'b1010;
                5: cmd = 4'b0001;
                default: cmd = 4'($urandom);
            endcase
            fn[4:1] = cmd;
        end
        return {c, op, fn, 4'($urandom), 4'($urandom)};
    endfunction

    initial begin
        reset = 1'b0;
        bus.Instr = 20'h00000;
        bus.ALUFlags = 4'b0000;
        bus.mem_ready = 1'b1;
        m_nzcv = 4'b0000;
        m_cnt = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        step(16'h0000, 1'b1, 4'b1111, "in_reset");
        check_cnt("in_reset");
        reset = 1'b1;

        run_instr(20'hE0921, 4'b0110, 0, 0, 1'b0);   // ADDS R1,R2,R3
        run_instr(20'h0A000, 4'b0000, 0, 0, 1'b0);   // BEQ taken (Z=1)
        run_instr(20'h4A000, 4'b0000, 0, 0, 1'b0);   // BMI not taken
        run_instr(20'hE1510, 4'b0100, 0, 0, 1'b0);   // CMP R1,R1
        run_instr(20'h0A000, 4'b0000, 0, 0, 1'b0);   // BEQ taken
        run_instr(20'h1A000, 4'b0000, 0, 0, 1'b0);   // BNE not taken
        run_instr(20'hE5910, 4'b0000, 0, 2, 1'b0);   // LDR, 2 stall cycles
        run_instr(20'hE5810, 4'b0000, 0, 3, 1'b0);   // STR, 3 stall cycles
        run_instr(20'hF0921, 4'b1111, 1, 0, 1'b0);   // never-execute

        for (int k = 0; k < 200; k++)
            run_instr(rand_instr(), 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);

        run_instr(20'hE5910, 4'b0000, 0, 1, 1'b1);   // LDR aborted by reset
        run_instr(20'h1A000, 4'b0000, 0, 0, 1'b0);   // NE after reset: Z=0 so taken

        for (int k = 0; k < 15; k++)
            run_instr(20'hE0821, 4'($urandom), 0, 0, 1'b0);
        run_instr(20'hEC000, 4'b0000, 0, 0, 1'b0);   // illegal op
        check_cnt("after_16");
        vectors++;
        assert (bus4.retired_cnt === 4'd0) else begin
            miscompares++;
            $error("FAIL wrap4: got %0d expected 0", bus4.retired_cnt);
        end
        run_instr(20'hE0821, 4'b0000, 0, 0, 1'b0);
        check_cnt("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
